// File: rtl/alu_pkg.sv
// Shared decode constants, occupancy encoding and the issued-bundle type
// for the ALU issue stage.
package alu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic        illegal;
    } issue_bundle_t;

    function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer between decode and the ALU: head register drives the
// outputs, the skid register catches one extra entry while the consumer stalls.
module alu_issue_skid
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  issue_bundle_t in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output issue_bundle_t out_data
);

    occ_t          state;
    issue_bundle_t head;
    issue_bundle_t skid;
    logic          accept;
    logic          drain;

    assign in_ready  = (state != OCC_TWO);
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = head;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCC_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        head  <= in_data;
                        state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({accept, drain})
                        2'b10: begin
                            skid  <= in_data;
                            state <= OCC_TWO;
                        end
                        2'b01: state <= OCC_EMPTY;
                        2'b11: head  <= in_data;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // in_ready is low here, so only a drain can occur
                    if (drain) begin
                        head  <= skid;
                        state <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I R/I-type operand issue stage: decode, immediate generation and operand
// capture into a 2-entry skid. Optional writeback bypass: define ISSUE_BYPASS_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_func3,
    output logic        out_illegal
);

    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic          is_r;
    logic          is_i;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    issue_bundle_t dec;
    issue_bundle_t issued;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign opcode   = in_instr[6:0];
    assign func3    = in_instr[14:12];
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);

`ifdef ISSUE_BYPASS_EN
    logic unused_bits;
    assign unused_bits = ^in_instr[11:7];
    assign rs1_val = (wb_valid && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
    assign rs2_val = (wb_valid && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;
`else
    logic unused_bits;
    assign unused_bits = ^{in_instr[11:7], wb_valid, wb_rd, wb_data};
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    always_comb begin
        dec         = '0;
        dec.opcode  = opcode;
        dec.func3   = func3;
        dec.illegal = !(is_r || is_i);
        // x0 reads as zero ahead of any data or bypass source
        if ((is_r || is_i) && rs1_addr != 5'd0)
            dec.a = rs1_val;
        if (is_i)
            dec.b = sext_imm12(in_instr[31:20]);
        else if (is_r && rs2_addr != 5'd0)
            dec.b = rs2_val;
    end

    alu_issue_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (issued)
    );

    assign out_a       = issued.a;
    assign out_b       = issued.b;
    assign out_opcode  = issued.opcode;
    assign out_func3   = issued.func3;
    assign out_illegal = issued.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expectations are hand-computed.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [6:0]  out_opcode;
    logic [2:0]  out_func3;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_opcode  (out_opcode),
        .out_func3   (out_func3),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {7'b0000000, rs2, rs1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {imm, rs1, f3, 5'd3, 7'b0010011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // offer one instruction for exactly one cycle
    task automatic offer(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2);
        in_instr = instr;
        rs1_data = d1;
        rs2_data = d2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rs1_data = 32'h5A5A_5A5A;
        rs2_data = 32'hA5A5_A5A5;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_instr = '0; rs1_data = '0; rs2_data = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_a, out_b} !== 64'd0) begin bad++; $display("FAIL reset_ab got=%h exp=0", {out_a, out_b}); end
        total++; if ({out_opcode, out_func3, out_illegal} !== 11'd0) begin bad++; $display("FAIL reset_ctl got=%h exp=0", {out_opcode, out_func3, out_illegal}); end
        step(); step();
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        in_instr  = mk_r(5'd2, 5'd1, 3'b010);
        #1;
        total++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin bad++; $display("FAIL rs_addr got=%h exp=%h", {rs1_addr, rs2_addr}, {5'd1, 5'd2}); end
        offer(mk_r(5'd2, 5'd1, 3'b010), 32'hFFFF_FFFB, 32'd10);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL slt_valid got=%b exp=1", out_valid); end
        total++; if (out_a !== 32'hFFFF_FFFB) begin bad++; $display("FAIL slt_a got=%h exp=fffffffb", out_a); end
        total++; if (out_b !== 32'd10) begin bad++; $display("FAIL slt_b got=%h exp=0000000a", out_b); end
        total++; if ({out_opcode, out_func3, out_illegal} !== {7'b0110011, 3'b010, 1'b0}) begin bad++; $display("FAIL slt_ctl got=%b_%b_%b exp=0110011_010_0", out_opcode, out_func3, out_illegal); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL slt_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_sltiu();
        out_ready = 1'b1;
        offer(mk_i(12'hFFF, 5'd1, 3'b011), 32'd50, 32'd99);
        total++; if (out_a !== 32'd50) begin bad++; $display("FAIL sltiu_a got=%h exp=00000032", out_a); end
        total++; if (out_b !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sltiu_b got=%h exp=ffffffff", out_b); end
        total++; if ({out_opcode, out_func3} !== {7'b0010011, 3'b011}) begin bad++; $display("FAIL sltiu_ctl got=%b_%b exp=0010011_011", out_opcode, out_func3); end
        offer(mk_i(12'h7FF, 5'd4, 3'b000), 32'd1, 32'd2);
        total++; if (out_b !== 32'h0000_07FF) begin bad++; $display("FAIL addi_pos_imm got=%h exp=000007ff", out_b); end
        offer(mk_i(12'h800, 5'd4, 3'b000), 32'd1, 32'd2);
        total++; if (out_b !== 32'hFFFF_F800) begin bad++; $display("FAIL addi_neg_imm got=%h exp=fffff800", out_b); end
        step();
    endtask

    task automatic test_illegal_x0();
        out_ready = 1'b1;
        offer({12'h123, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'h1111_1111, 32'h2222_2222);
        total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL load_illegal got=%b exp=1", out_illegal); end
        total++; if ({out_a, out_b} !== 64'd0) begin bad++; $display("FAIL load_ab got=%h exp=0", {out_a, out_b}); end
        total++; if ({out_opcode, out_func3} !== {7'b0000011, 3'b010}) begin bad++; $display("FAIL load_ctl got=%b_%b exp=0000011_010", out_opcode, out_func3); end
        offer(mk_r(5'd2, 5'd0, 3'b000), 32'h1234, 32'd8);
        total++; if (out_a !== 32'd0) begin bad++; $display("FAIL x0_rs1 got=%h exp=0", out_a); end
        total++; if (out_b !== 32'd8) begin bad++; $display("FAIL x0_rs1_b got=%h exp=00000008", out_b); end
        offer(mk_r(5'd0, 5'd5, 3'b000), 32'h77, 32'hBEEF);
        total++; if ({out_a, out_b} !== {32'h77, 32'd0}) begin bad++; $display("FAIL x0_rs2 got=%h exp=%h", {out_a, out_b}, {32'h77, 32'd0}); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk_r(5'd2, 5'd1, 3'b000); rs1_data = 32'hA; rs2_data = 32'h1;
        #0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
        step();
        in_instr  = mk_r(5'd2, 5'd1, 3'b010); rs1_data = 32'hB; rs2_data = 32'h2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        step();
        in_instr  = mk_r(5'd2, 5'd1, 3'b011); rs1_data = 32'hC; rs2_data = 32'h3;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
        total++; if ({out_valid, out_a, out_func3} !== {1'b1, 32'hA, 3'b000}) begin bad++; $display("FAIL b2b_hold0 got=%h exp=%h", {out_valid, out_a, out_func3}, {1'b1, 32'hA, 3'b000}); end
        step();
        in_valid = 1'b0;
        rs1_data = 32'hDEAD_0000;
        total++; if ({out_a, out_b, in_ready} !== {32'hA, 32'h1, 1'b0}) begin bad++; $display("FAIL b2b_hold1 got=%h exp=%h", {out_a, out_b, in_ready}, {32'hA, 32'h1, 1'b0}); end
        out_ready = 1'b1;
        step();
        total++; if ({out_valid, out_a, out_b, out_func3} !== {1'b1, 32'hB, 32'h2, 3'b010}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {out_valid, out_a, out_b, out_func3}, {1'b1, 32'hB, 32'h2, 3'b010}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_drain got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_still_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk_r(5'd2, 5'd1, 3'b000); rs1_data = 32'h100; rs2_data = 32'h1;
        step();
        total++; if (out_a !== 32'h100) begin bad++; $display("FAIL stream_first got=%h exp=00000100", out_a); end
        in_instr  = mk_r(5'd2, 5'd1, 3'b000); rs1_data = 32'h200; rs2_data = 32'h2;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, out_a, in_ready} !== {1'b1, 32'h200, 1'b1}) begin bad++; $display("FAIL stream_second got=%h exp=%h", {out_valid, out_a, in_ready}, {1'b1, 32'h200, 1'b1}); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
`ifdef ISSUE_BYPASS_EN
        exp_a = 32'hDEAD;
`else
        exp_a = 32'd7;
`endif
        out_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
        offer(mk_r(5'd2, 5'd1, 3'b000), 32'd7, 32'd9);
        total++; if (out_a !== exp_a) begin bad++; $display("FAIL bypass_hit got=%h exp=%h", out_a, exp_a); end
        total++; if (out_b !== 32'd9) begin bad++; $display("FAIL bypass_b_untouched got=%h exp=00000009", out_b); end
        wb_rd = 5'd0;
        offer(mk_r(5'd2, 5'd1, 3'b000), 32'd7, 32'd9);
        total++; if (out_a !== 32'd7) begin bad++; $display("FAIL bypass_rd0 got=%h exp=00000007", out_a); end
        wb_rd = 5'd0;
        offer(mk_r(5'd2, 5'd0, 3'b000), 32'd7, 32'd9);
        total++; if (out_a !== 32'd0) begin bad++; $display("FAIL bypass_x0 got=%h exp=0", out_a); end
        wb_valid = 1'b0; wb_rd = 5'd1;
        offer(mk_r(5'd2, 5'd1, 3'b000), 32'd7, 32'd9);
        total++; if (out_a !== 32'd7) begin bad++; $display("FAIL bypass_wb_invalid got=%h exp=00000007", out_a); end
        wb_rd = 5'd0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk_r(5'd2, 5'd1, 3'b000); rs1_data = 32'h31; rs2_data = 32'h32;
        step(); step();
        in_valid = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL mid_full got=%b exp=10", {out_valid, in_ready}); end
        rst = 1'b1;
        #1;
        total++; if ({out_valid, out_a} !== 33'd0) begin bad++; $display("FAIL mid_async got=%h exp=0", {out_valid, out_a}); end
        #1 rst = 1'b0;
        step();
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL mid_after got=%b exp=10", {in_ready, out_valid}); end
        out_ready = 1'b1;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_slt();
        test_sltiu();
        test_illegal_x0();
        test_back_to_back();
        test_stream();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
